// File: rtl/reg_readout.sv
// +-------------------------------------------------------------------------+
// | Module      : reg_readout                                               |
// | Description : Three bus-loaded registers read out in sequence over a    |
// |               shared tri-state bus with a valid/ready handshake.        |
// | Revision    : 1.0                                                       |
// +-------------------------------------------------------------------------+
`default_nettype none

module reg_readout #(
  parameter int n = 8
) (
  input  logic         Clock,
  input  logic         Resetn,
  input  logic         w,
  input  logic [n-1:0] Data,
  input  logic         Extern,
  input  logic         RinExt1,
  input  logic         RinExt2,
  input  logic         RinExt3,
  input  logic         Ready,
  output tri   [n-1:0] BusWires,
  output logic [n-1:0] DataOut,
  output logic         Valid,
  output logic [1:0]   Index,
  output logic         Busy,
  output logic         Done
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    S1   = 3'd1,
    S2   = 3'd2,
    S3   = 3'd3,
    FIN  = 3'd4
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [n-1:0]   r_reg [3];
  logic [2:0]     w_rin;
  logic [2:0]     w_load;
  logic           w_bus_en;
  logic [n-1:0]   w_bus_val;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    Valid       = 1'b0;
    Index       = 2'd0;
    Busy        = 1'b1;
    Done        = 1'b0;
    unique case (r_state)
      IDLE: begin
        Busy = 1'b0;
        if (w) w_state_nxt = S1;
      end
      S1: begin
        Valid = 1'b1;
        Index = 2'd1;
        if (Ready) w_state_nxt = S2;
      end
      S2: begin
        Valid = 1'b1;
        Index = 2'd2;
        if (Ready) w_state_nxt = S3;
      end
      S3: begin
        Valid = 1'b1;
        Index = 2'd3;
        if (Ready) w_state_nxt = FIN;
      end
      FIN: begin
        Done        = 1'b1;
        w_state_nxt = IDLE;
      end
      default: begin
        Busy        = 1'b0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Single bus source select: at most one driver is ever enabled.
  always_comb begin
    w_bus_en  = 1'b1;
    w_bus_val = '0;
    case (r_state)
      S1:      w_bus_val = r_reg[0];
      S2:      w_bus_val = r_reg[1];
      S3:      w_bus_val = r_reg[2];
      IDLE: begin
        w_bus_en  = Extern;
        w_bus_val = Data;
      end
      default: w_bus_en = 1'b0;
    endcase
  end

  assign BusWires = w_bus_en ? w_bus_val : {n{1'bz}};
  assign DataOut  = w_bus_val;

  // External load requests only count in IDLE so contents are frozen during readout.
  assign w_rin  = {RinExt3, RinExt2, RinExt1};
  assign w_load = (r_state == IDLE) ? w_rin : 3'b000;

  for (genvar k = 0; k < 3; k++) begin : g_reg
    always_ff @(posedge Clock) begin
      if (w_load[k]) r_reg[k] <= w_bus_val;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_reg_readout.sv
// +-------------------------------------------------------------------------+
// | Module      : tb_reg_readout                                            |
// | Description : Directed self-checking bench for reg_readout.             |
// | Revision    : 1.0                                                       |
// +-------------------------------------------------------------------------+
`default_nettype none

module tb_reg_readout;

  logic       Clock;
  logic       Resetn;
  logic       w;
  logic [7:0] Data;
  logic       Extern;
  logic       RinExt1;
  logic       RinExt2;
  logic       RinExt3;
  logic       Ready;
  wire  [7:0] BusWires;
  logic [7:0] DataOut;
  logic       Valid;
  logic [1:0] Index;
  logic       Busy;
  logic       Done;

  int total;
  int bad;

  reg_readout #(.n(8)) dut (
    .Clock    (Clock),
    .Resetn   (Resetn),
    .w        (w),
    .Data     (Data),
    .Extern   (Extern),
    .RinExt1  (RinExt1),
    .RinExt2  (RinExt2),
    .RinExt3  (RinExt3),
    .Ready    (Ready),
    .BusWires (BusWires),
    .DataOut  (DataOut),
    .Valid    (Valid),
    .Index    (Index),
    .Busy     (Busy),
    .Done     (Done)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Checks the full Moore output set of a word-presenting state.
  task automatic check_word(input string tag, input logic [1:0] idx, input logic [7:0] val);
    check({tag, "_valid"}, {31'd0, Valid}, 32'd1);
    check({tag, "_index"}, {30'd0, Index}, {30'd0, idx});
    check({tag, "_data"},  {24'd0, DataOut}, {24'd0, val});
    check({tag, "_bus"},   {24'd0, BusWires}, {24'd0, val});
    check({tag, "_busy"},  {31'd0, Busy}, 32'd1);
    check({tag, "_done"},  {31'd0, Done}, 32'd0);
  endtask

  task automatic check_fin(input string tag);
    check({tag, "_done"},  {31'd0, Done}, 32'd1);
    check({tag, "_valid"}, {31'd0, Valid}, 32'd0);
    check({tag, "_index"}, {30'd0, Index}, 32'd0);
    check({tag, "_busy"},  {31'd0, Busy}, 32'd1);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"},  {31'd0, Busy}, 32'd0);
    check({tag, "_done"},  {31'd0, Done}, 32'd0);
    check({tag, "_valid"}, {31'd0, Valid}, 32'd0);
    check({tag, "_index"}, {30'd0, Index}, 32'd0);
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    Resetn  = 1'b0;
    w       = 1'b0;
    Data    = 8'h00;
    Extern  = 1'b0;
    RinExt1 = 1'b0;
    RinExt2 = 1'b0;
    RinExt3 = 1'b0;
    Ready   = 1'b1;

    tick();
    check_idle("reset");
    tick();
    Resetn = 1'b1;

    // Load R1..R3 through the external driver.
    Extern = 1'b1; Data = 8'h11; RinExt1 = 1'b1;
    tick();
    check("ext_drive_bus", {24'd0, BusWires}, 32'h11);
    RinExt1 = 1'b0; Data = 8'h22; RinExt2 = 1'b1;
    tick();
    RinExt2 = 1'b0; Data = 8'h33; RinExt3 = 1'b1;
    tick();
    RinExt3 = 1'b0; Extern = 1'b0;

    // Full-speed readout.
    w = 1'b1;
    tick();
    w = 1'b0;
    check_word("seq1_s1", 2'd1, 8'h11);
    tick();
    check_word("seq1_s2", 2'd2, 8'h22);
    tick();
    check_word("seq1_s3", 2'd3, 8'h33);
    tick();
    check_fin("seq1_fin");
    tick();
    check_idle("seq1_idle");

    // Stall three cycles in S2, with an external load attempt that must be ignored.
    w = 1'b1;
    tick();
    w = 1'b0;
    check_word("seq2_s1", 2'd1, 8'h11);
    tick();
    Ready = 1'b0;
    Extern = 1'b1; Data = 8'hAA; RinExt1 = 1'b1;
    #1;
    check_word("seq2_stall1", 2'd2, 8'h22);
    tick();
    check_word("seq2_stall2", 2'd2, 8'h22);
    tick();
    check_word("seq2_stall3", 2'd2, 8'h22);
    Ready = 1'b1; Extern = 1'b0; RinExt1 = 1'b0;
    tick();
    check_word("seq2_s3", 2'd3, 8'h33);
    tick();
    check_fin("seq2_fin");
    tick();
    check_idle("seq2_idle");

    // Abort in S3 with an asynchronous reset.
    w = 1'b1;
    tick();
    w = 1'b0;
    tick();
    tick();
    check_word("seq3_s3", 2'd3, 8'h33);
    #2;
    Resetn = 1'b0;
    #1;
    check_idle("abort_async");
    tick();
    check_idle("abort_held");
    Resetn = 1'b1;
    w = 1'b1;
    tick();
    w = 1'b0;
    check_word("seq4_s1_r1_kept", 2'd1, 8'h11);
    tick();
    check_word("seq4_s2", 2'd2, 8'h22);
    tick();
    check_word("seq4_s3", 2'd3, 8'h33);
    tick();
    check_fin("seq4_fin");
    tick();
    check_idle("seq4_idle");

    // Load and start at the same edge; w then held high through FIN.
    Extern = 1'b1; Data = 8'h5C; RinExt1 = 1'b1; w = 1'b1;
    tick();
    Extern = 1'b0; RinExt1 = 1'b0;
    check_word("seq5_s1", 2'd1, 8'h5C);
    tick();
    check_word("seq5_s2", 2'd2, 8'h22);
    tick();
    check_word("seq5_s3", 2'd3, 8'h33);
    tick();
    check_fin("seq5_fin");
    tick();
    check_idle("seq5_idle");
    tick();
    w = 1'b0;
    check_word("seq6_s1", 2'd1, 8'h5C);
    tick();
    check_word("seq6_s2", 2'd2, 8'h22);
    tick();
    check_word("seq6_s3", 2'd3, 8'h33);
    tick();
    check_fin("seq6_fin");
    tick();
    check_idle("seq6_idle");
    tick();
    check_idle("seq6_stay_idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
